// File: rtl/hdl1_sweep_ctrl_if.sv
// Purpose: bundles the host-side handshake/result signals and the HDL_1 drive/sense
//          pair of the sweep controller into one interface.
// Signals:
//   start, abort        host -> controller requests
//   abcd_out, f_in      controller -> HDL_1 inputs, HDL_1 output F -> controller
//   busy, done, pass    sweep status
//   fail_count, first_fail, first_fail_valid, captured   sweep results
// Modports: master = host / HDL_1 side, slave = sweep controller.
interface hdl1_sweep_ctrl_if;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned TBL_W = 16;

  logic             start;
  logic             abort;
  logic [IDX_W-1:0] abcd_out;
  logic             f_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] fail_count;
  logic [IDX_W-1:0] first_fail;
  logic             first_fail_valid;
  logic [TBL_W-1:0] captured;

  modport master (
    output start, abort, f_in,
    input  abcd_out, busy, done, pass, fail_count, first_fail, first_fail_valid, captured
  );

  modport slave (
    input  start, abort, f_in,
    output abcd_out, busy, done, pass, fail_count, first_fail, first_fail_valid, captured
  );
endinterface

// File: rtl/hdl1_sweep_ctrl.sv
// Purpose: steps the 4-input HDL_1 block through all 16 input combinations, samples F
//          after a settle window and compares it with EXPECTED_MASK, reporting the
//          captured truth table, mismatch count and first failing minterm.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    hdl1_sweep_ctrl_if.slave: start/abort in, abcd_out out, f_in in,
//          busy/done/pass/fail_count/first_fail/first_fail_valid/captured out
module hdl1_sweep_ctrl #(
  parameter logic [15:0] EXPECTED_MASK = 16'hDF03,
  parameter int unsigned SETTLE        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  hdl1_sweep_ctrl_if.slave    bus
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned FC_W   = 5;
  localparam int unsigned TBL_W  = 16;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(15);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SETTLE);
  localparam logic [FC_W-1:0]   FC_MAX   = FC_W'(16);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    abcd_q, abcd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic [IDX_W-1:0]    ff_q, ff_d;
  logic                ffv_q, ffv_d;
  logic [TBL_W-1:0]    cap_q, cap_d;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    cap_d   = cap_q;

    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort; results are cleared only here
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          idx_d   = '0;
          hold_d  = '0;
          abcd_d  = '0;
          cap_d   = '0;
          fc_d    = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end

      RUN: begin
        if (bus.abort) begin
          // partial results are left in place but pass stays 0
          state_d = IDLE;
          busy_d  = 1'b0;
          abcd_d  = '0;
          idx_d   = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_MAX) begin
          cap_d[idx_q] = bus.f_in;
          if (bus.f_in != EXPECTED_MASK[idx_q]) begin
            if (fc_q != FC_MAX) begin
              fc_d = fc_q + FC_W'(1);
            end
            if (!ffv_q) begin
              ff_d  = idx_q;
              ffv_d = 1'b1;
            end
          end
          hold_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abcd_d  = '0;
            pass_d  = (fc_d == '0);
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            abcd_d = idx_q + IDX_W'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        abcd_d  = '0;
      end
    endcase
  end

  assign bus.abcd_out         = abcd_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fc_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.captured         = cap_q;

endmodule

// File: tb/tb_hdl1_sweep_ctrl.sv
// Purpose: self-checking bench for hdl1_sweep_ctrl; two instances (SETTLE = 1 and 3)
//          share clk/rst_n, each with a behavioural HDL_1 (optionally faulted) on f_in.
module tb_hdl1_sweep_ctrl;

  typedef struct {
    logic        pass;
    logic [4:0]  fc;
    logic [3:0]  ff;
    logic        ffv;
    logic [15:0] cap;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hdl1_sweep_ctrl_if b1 ();
  hdl1_sweep_ctrl_if b3 ();

  hdl1_sweep_ctrl #(.EXPECTED_MASK(16'hDF03), .SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  hdl1_sweep_ctrl #(.EXPECTED_MASK(16'hDF03), .SETTLE(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  logic start1, abort1, start3, abort3;
  int   mode1, mode3;
  int   sel;
  int   n_vec;
  int   n_err;

  exp_t       sb[$];
  logic [3:0] aq[$];

  // F(A,B,C,D) = m(0,1,8,9,10,11,12,14,15), with optional injected faults
  function automatic logic model_f(input int m, input logic [3:0] v);
    logic a, b, c, d, f;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    f = (~a & ~b & ~c) | (a & ~b) | (a & b & (c | ~d));
    case (m)
      1:       model_f = 1'b0;
      2:       model_f = (v == 4'd10) ? ~f : f;
      3:       model_f = ~f;
      default: model_f = f;
    endcase
  endfunction

  assign b1.start = start1;
  assign b1.abort = abort1;
  assign b1.f_in  = model_f(mode1, b1.abcd_out);
  assign b3.start = start3;
  assign b3.abort = abort3;
  assign b3.f_in  = model_f(mode3, b3.abcd_out);

  logic        v_busy, v_done, v_pass, v_ffv;
  logic [3:0]  v_abcd, v_ff;
  logic [4:0]  v_fc;
  logic [15:0] v_cap;
  assign v_busy = (sel == 1) ? b3.busy : b1.busy;
  assign v_done = (sel == 1) ? b3.done : b1.done;
  assign v_pass = (sel == 1) ? b3.pass : b1.pass;
  assign v_ffv  = (sel == 1) ? b3.first_fail_valid : b1.first_fail_valid;
  assign v_abcd = (sel == 1) ? b3.abcd_out : b1.abcd_out;
  assign v_ff   = (sel == 1) ? b3.first_fail : b1.first_fail;
  assign v_fc   = (sel == 1) ? b3.fail_count : b1.fail_count;
  assign v_cap  = (sel == 1) ? b3.captured : b1.captured;

  task automatic drive_start(input logic v);
    if (sel == 1) start3 = v; else start1 = v;
  endtask

  task automatic drive_abort(input logic v);
    if (sel == 1) abort3 = v; else abort1 = v;
  endtask

  task automatic set_mode(input int m);
    if (sel == 1) mode3 = m; else mode1 = m;
  endtask

  // Build expected results and the abcd_out sequence from the behavioural model
  task automatic push_expect(input int m, input int settle);
    exp_t e;
    e.cap = '0; e.fc = '0; e.ff = '0; e.ffv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      e.cap[i] = model_f(m, v);
      if (model_f(m, v) != model_f(0, v)) begin
        e.fc = e.fc + 5'd1;
        if (!e.ffv) begin
          e.ff  = v;
          e.ffv = 1'b1;
        end
      end
    end
    e.pass = (e.fc == 5'd0);
    e.lat  = 16 * (settle + 1);
    sb.push_back(e);
    for (int k = 0; k < e.lat; k++) aq.push_back(4'(k / (settle + 1)));
  endtask

  // One full sweep; optionally pulses start again at cycle glitch_k while running
  task automatic run_sweep(input int m, input int settle, input int glitch_k, input string nm);
    exp_t e;
    int   k;
    logic glitch;
    set_mode(m);
    push_expect(m, settle);
    @(negedge clk); drive_start(1'b1);
    @(negedge clk); drive_start(1'b0);
    k = 0;
    glitch = 1'b0;
    while (!v_done && k <= 16 * (settle + 1) + 8) begin
      if (aq.size() > 0) begin
        logic [3:0] ea;
        ea = aq.pop_front();
        n_vec++;
        if (v_busy !== 1'b1 || v_abcd !== ea) begin
          n_err++;
          $display("FAIL %s abcd/busy cycle %0d: got abcd=%0d busy=%b, want abcd=%0d busy=1",
                   nm, k, v_abcd, v_busy, ea);
        end
      end
      if (k == glitch_k) begin
        drive_start(1'b1);
        glitch = 1'b1;
      end
      @(negedge clk);
      if (glitch) begin
        drive_start(1'b0);
        glitch = 1'b0;
      end
      k++;
    end
    e = sb.pop_front();
    n_vec++;
    if (!v_done || k != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got done=%b at cycle %0d, want done at %0d", nm, v_done, k, e.lat);
    end
    n_vec++;
    if (v_busy !== 1'b0 || aq.size() != 0) begin
      n_err++;
      $display("FAIL %s busy at done: got busy=%b leftover=%0d, want busy=0 leftover=0",
               nm, v_busy, aq.size());
    end
    aq.delete();
    n_vec++;
    if ({v_pass, v_fc, v_ff, v_ffv} !== {e.pass, e.fc, e.ff, e.ffv}) begin
      n_err++;
      $display("FAIL %s results: got pass=%b fc=%0d ff=%0d ffv=%b, want pass=%b fc=%0d ff=%0d ffv=%b",
               nm, v_pass, v_fc, v_ff, v_ffv, e.pass, e.fc, e.ff, e.ffv);
    end
    n_vec++;
    if (v_cap !== e.cap) begin
      n_err++;
      $display("FAIL %s captured: got %h, want %h", nm, v_cap, e.cap);
    end
    @(negedge clk);
    n_vec++;
    if (v_done !== 1'b0 || v_abcd !== 4'd0) begin
      n_err++;
      $display("FAIL %s done pulse width: got done=%b abcd=%0d, want done=0 abcd=0", nm, v_done, v_abcd);
    end
    @(negedge clk);
    n_vec++;
    if (v_busy !== 1'b0 || v_pass !== e.pass) begin
      n_err++;
      $display("FAIL %s idle after done: got busy=%b pass=%b, want busy=0 pass=%b", nm, v_busy, v_pass, e.pass);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start1 = i[0]; abort1 = i[1]; start3 = i[0]; abort3 = ~i[1];
    end
    n_vec++;
    if ({b1.busy, b1.done, b1.pass, b1.fail_count, b1.first_fail, b1.first_fail_valid,
         b1.captured, b1.abcd_out} !== 33'd0 ||
        {b3.busy, b3.done, b3.pass, b3.fail_count, b3.first_fail, b3.first_fail_valid,
         b3.captured, b3.abcd_out} !== 33'd0) begin
      n_err++;
      $display("FAIL reset outputs: got busy=%b/%b cap=%h/%h abcd=%0d/%0d, want all 0",
               b1.busy, b3.busy, b1.captured, b3.captured, b1.abcd_out, b3.abcd_out);
    end
    start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({b1.busy, b1.done, b3.busy, b3.done, b1.abcd_out} !== 8'd0) begin
      n_err++;
      $display("FAIL reset release idle: got busy=%b/%b done=%b/%b, want 0", b1.busy, b3.busy, b1.done, b3.done);
    end
  endtask

  task automatic test_abort();
    int k;
    sel = 0;
    set_mode(0);
    @(negedge clk); drive_start(1'b1);
    @(negedge clk); drive_start(1'b0);
    k = 0;
    while (v_abcd != 4'd5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (v_abcd !== 4'd5) begin
      n_err++;
      $display("FAIL abort reach vector 5: got abcd=%0d, want 5", v_abcd);
    end
    drive_abort(1'b1);
    @(negedge clk); drive_abort(1'b0);
    n_vec++;
    if (v_busy !== 1'b0 || v_abcd !== 4'd0 || v_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort response: got busy=%b abcd=%0d done=%b, want 0/0/0", v_busy, v_abcd, v_done);
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (v_done || v_busy) k++;
    end
    n_vec++;
    if (k != 0 || v_pass !== 1'b0) begin
      n_err++;
      $display("FAIL abort no done: got %0d busy/done cycles pass=%b, want 0 and pass=0", k, v_pass);
    end
    run_sweep(0, 1, -1, "after_abort");
  endtask

  task automatic test_reset_mid_sweep();
    int k;
    sel = 1;
    set_mode(0);
    @(negedge clk); drive_start(1'b1);
    @(negedge clk); drive_start(1'b0);
    k = 0;
    while (v_abcd != 4'd9 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (v_abcd !== 4'd9 || v_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset reach vector 9: got abcd=%0d busy=%b, want 9/1", v_abcd, v_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({b3.busy, b3.done, b3.pass, b3.fail_count, b3.first_fail, b3.first_fail_valid,
         b3.captured, b3.abcd_out} !== 33'd0) begin
      n_err++;
      $display("FAIL midreset async clear: got busy=%b abcd=%0d cap=%h fc=%0d, want all 0",
               b3.busy, b3.abcd_out, b3.captured, b3.fail_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 3, -1, "settle3");
  endtask

  initial begin
    n_vec = 0; n_err = 0; sel = 0;
    mode1 = 0; mode3 = 0;
    start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    test_reset();
    sel = 0;
    run_sweep(0, 1, -1, "golden");
    run_sweep(1, 1, -1, "tied_zero");
    run_sweep(2, 1, -1, "flip_10");
    run_sweep(3, 1, -1, "all_inverted");
    test_abort();
    run_sweep(0, 1, 10, "start_in_run");
    run_sweep(0, 1, -1, "back_to_back");
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
